// File: rtl/scan_nmux.sv
// Registered N:1 channel multiplexer with manual select and auto-scan modes.
// Auto-scan steps an internal channel counter with a programmable dwell per channel.
module scan_nmux #(
  parameter  int unsigned N_CH  = 16,
  parameter  int unsigned W     = 1,
  parameter  int unsigned DWELL = 1,
  localparam int unsigned SEL_W = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      y,
  output logic [SEL_W-1:0]  sel_out,
  output logic              valid,
  output logic              wrap,
  output logic              err
);

  localparam logic [0:0]       ST_MAN  = 1'b0;
  localparam logic [0:0]       ST_SCAN = 1'b1;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [15:0]      LAST_DC = 16'(DWELL - 1);

  logic [0:0]       state;
  logic [SEL_W-1:0] ch;
  logic [15:0]      dc;

  logic             entering;
  logic [SEL_W-1:0] cur_ch;
  logic [15:0]      cur_dc;
  logic             dwell_done;
  logic             illegal;
  logic [SEL_W-1:0] pick;
  logic [W-1:0]     pick_data;
  logic [SEL_W-1:0] ch_n;
  logic [15:0]      dc_n;
  logic             wrap_n;

  always_comb begin
    entering   = mode && (state == ST_MAN);
    // Entry behaves as a step from ch=0/dc=0 so the entry edge is the first dwell cycle.
    cur_ch     = entering ? '0 : ch;
    cur_dc     = entering ? '0 : dc;
    dwell_done = (cur_dc == LAST_DC);
    illegal    = !mode && (sel > LAST_CH);
    pick       = mode ? cur_ch : sel;

    pick_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (pick == SEL_W'(k)) pick_data = in[k*W +: W];
    end

    ch_n = cur_ch;
    dc_n = cur_dc + 16'd1;
    if (dwell_done) begin
      dc_n = '0;
      ch_n = (cur_ch == LAST_CH) ? '0 : cur_ch + SEL_W'(1);
    end

    // Counters only return to 0/0 after the last channel's dwell, so seeing that
    // origin while already scanning marks the first sample of a new pass.
    wrap_n = mode && !entering && (cur_ch == '0) && (cur_dc == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_MAN;
      ch      <= '0;
      dc      <= '0;
      y       <= '0;
      sel_out <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else if (en) begin
      state   <= mode ? ST_SCAN : ST_MAN;
      y       <= illegal ? '0 : pick_data;
      sel_out <= pick;
      valid   <= 1'b1;
      wrap    <= wrap_n;
      err     <= illegal;
      if (mode) begin
        ch <= ch_n;
        dc <= dc_n;
      end else begin
        ch <= '0;
        dc <= '0;
      end
    end else begin
      valid <= 1'b0;
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_nmux.sv
// Bench for scan_nmux: two instances (16x1 dwell 1, 5x4 dwell 3) checked against a
// position-counting reference model, directed sequences and a random phase.
module tb_scan_nmux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [15:0] a_in;
  logic [3:0]  a_sel;
  logic        a_mode, a_en;
  logic [0:0]  a_y;
  logic [3:0]  a_so;
  logic        a_v, a_w, a_e;

  logic [19:0] b_in;
  logic [2:0]  b_sel;
  logic        b_mode, b_en;
  logic [3:0]  b_y;
  logic [2:0]  b_so;
  logic        b_v, b_w, b_e;

  scan_nmux #(.N_CH(16), .W(1), .DWELL(1)) u_a (
    .clk(clk), .rst(rst), .in(a_in), .sel(a_sel), .mode(a_mode), .en(a_en),
    .y(a_y), .sel_out(a_so), .valid(a_v), .wrap(a_w), .err(a_e)
  );

  scan_nmux #(.N_CH(5), .W(4), .DWELL(3)) u_b (
    .clk(clk), .rst(rst), .in(b_in), .sel(b_sel), .mode(b_mode), .en(b_en),
    .y(b_y), .sel_out(b_so), .valid(b_v), .wrap(b_w), .err(b_e)
  );

  // p counts en=1 scan cycles since entry; channel and wrap follow from plain arithmetic.
  typedef struct {
    bit          scan;
    int unsigned p;
    logic [31:0] y;
    logic [31:0] so;
    bit          v, w, e;
  } mdl_t;

  mdl_t ma, mb;
  int   checks = 0;
  int   errors = 0;

  function automatic mdl_t step(input mdl_t m, input int unsigned n, input int unsigned d,
                                input int unsigned w, input bit r, input bit en,
                                input bit mode, input int unsigned sel,
                                input logic [255:0] din);
    mdl_t s;
    int unsigned c;
    logic [31:0] mask;
    s = m;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (r) begin
      s.scan = 0; s.p = 0; s.y = '0; s.so = '0; s.v = 0; s.w = 0; s.e = 0;
    end else if (!en) begin
      s.v = 0; s.w = 0;
    end else if (mode) begin
      s.p    = m.scan ? m.p + 1 : 0;
      s.scan = 1;
      c      = (s.p / d) % n;
      s.y    = 32'(din >> (c * w)) & mask;
      s.so   = c;
      s.e    = 0;
      s.v    = 1;
      s.w    = (s.p != 0) && (s.p % (n * d) == 0);
    end else begin
      s.scan = 0;
      s.so   = sel;
      s.v    = 1;
      s.w    = 0;
      if (sel >= n) begin
        s.y = '0; s.e = 1;
      end else begin
        s.y = 32'(din >> (sel * w)) & mask; s.e = 0;
      end
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ma = step(ma, 16, 1, 1, rst, a_en, a_mode, int'(a_sel), 256'(a_in));
    mb = step(mb, 5, 3, 4, rst, b_en, b_mode, int'(b_sel), 256'(b_in));
    #1;
    chk("a_y", 32'(a_y), ma.y);
    chk("a_sel_out", 32'(a_so), ma.so);
    chk("a_valid", 32'(a_v), 32'(ma.v));
    chk("a_wrap", 32'(a_w), 32'(ma.w));
    chk("a_err", 32'(a_e), 32'(ma.e));
    chk("b_y", 32'(b_y), mb.y);
    chk("b_sel_out", 32'(b_so), mb.so);
    chk("b_valid", 32'(b_v), 32'(mb.v));
    chk("b_wrap", 32'(b_w), 32'(mb.w));
    chk("b_err", 32'(b_e), 32'(mb.e));
  endtask

  typedef struct {
    logic [15:0] din;
    logic [3:0]  sel;
    logic        ey;
    logic [3:0]  eso;
  } vec_t;

  vec_t        tbl[17];
  logic [15:0] pat;
  int          dwell_a[7]  = '{0, 0, 0, 1, 1, 1, 2};
  int          dwell_b[9]  = '{2, 2, 3, 3, 3, 4, 4, 4, 0};

  initial begin
    for (int k = 0; k < 16; k++) tbl[k] = '{16'h0001 << k, 4'(k), 1'b1, 4'(k)};
    tbl[16] = '{16'h0400, 4'd3, 1'b0, 4'd3};

    rst = 1'b1;
    a_in = '0; a_sel = '0; a_mode = 1'b0; a_en = 1'b1;
    b_in = 20'h54321; b_sel = '0; b_mode = 1'b0; b_en = 1'b1;
    ma = '{scan: 0, p: 0, y: '0, so: '0, v: 0, w: 0, e: 0};
    mb = ma;

    tick();
    chk("reset_y", 32'(a_y), 32'd0);
    chk("reset_sel_out", 32'(a_so), 32'd0);
    chk("reset_valid", 32'(a_v), 32'd0);
    chk("reset_wrap", 32'(a_w), 32'd0);
    chk("reset_err", 32'(a_e), 32'd0);
    rst = 1'b0;

    // Manual sweep
    for (int i = 0; i < 17; i++) begin
      a_in = tbl[i].din; a_sel = tbl[i].sel;
      tick();
      chk("sweep_y", 32'(a_y), 32'(tbl[i].ey));
      chk("sweep_sel_out", 32'(a_so), 32'(tbl[i].eso));
      chk("sweep_valid", 32'(a_v), 32'd1);
    end

    // Scan wrap over 34 cycles
    pat = 16'hA5A5;
    a_in = pat; a_mode = 1'b1;
    for (int n = 0; n < 34; n++) begin
      tick();
      chk("scan_sel_out", 32'(a_so), 32'(n % 16));
      chk("scan_y", 32'(a_y), 32'(pat[n % 16]));
      chk("scan_wrap", 32'(a_w), 32'((n == 16) || (n == 32)));
    end

    // Mode switch while ch=9 pending, then re-entry
    for (int n = 34; n < 41; n++) tick();
    chk("pre_switch_sel_out", 32'(a_so), 32'd8);
    a_mode = 1'b0; a_sel = 4'd4; a_in = 16'h0010;
    tick();
    chk("switch_sel_out", 32'(a_so), 32'd4);
    chk("switch_y", 32'(a_y), 32'd1);
    a_mode = 1'b1;
    tick();
    chk("reentry_sel_out", 32'(a_so), 32'd0);
    chk("reentry_wrap", 32'(a_w), 32'd0);

    // Reset mid-scan at ch=7
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("prereset_sel_out", 32'(a_so), 32'(i));
    end
    rst = 1'b1;
    tick();
    chk("midrst_y", 32'(a_y), 32'd0);
    chk("midrst_sel_out", 32'(a_so), 32'd0);
    chk("midrst_valid", 32'(a_v), 32'd0);
    chk("midrst_wrap", 32'(a_w), 32'd0);
    chk("midrst_err", 32'(a_e), 32'd0);
    rst = 1'b0;
    tick();
    chk("postrst_sel_out", 32'(a_so), 32'd0);
    chk("postrst_valid", 32'(a_v), 32'd1);
    chk("postrst_wrap", 32'(a_w), 32'd0);

    // Leave scan on the edge that would wrap
    for (int i = 1; i <= 15; i++) tick();
    a_mode = 1'b0; a_sel = 4'd2; a_in = 16'h0004;
    tick();
    chk("nowrap_on_exit_wrap", 32'(a_w), 32'd0);
    chk("nowrap_on_exit_sel_out", 32'(a_so), 32'd2);
    chk("nowrap_on_exit_y", 32'(a_y), 32'd1);

    // Illegal select on the 5-channel instance
    b_sel = 3'd6;
    tick();
    chk("illegal_y", 32'(b_y), 32'd0);
    chk("illegal_err", 32'(b_e), 32'd1);
    chk("illegal_sel_out", 32'(b_so), 32'd6);
    b_sel = 3'd2;
    tick();
    chk("legal_err", 32'(b_e), 32'd0);
    chk("legal_y", 32'(b_y), 32'h3);

    // Dwell of 3 with a 4-cycle pause in channel 2
    b_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("dwell_sel_out", 32'(b_so), 32'(dwell_a[i]));
      chk("dwell_y", 32'(b_y), 32'(dwell_a[i] + 1));
    end
    b_en = 1'b0; b_in = 20'hABCDE;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pause_valid", 32'(b_v), 32'd0);
      chk("pause_sel_out", 32'(b_so), 32'd2);
      chk("pause_y", 32'(b_y), 32'h3);
    end
    b_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("resume_sel_out", 32'(b_so), 32'(dwell_b[i]));
      chk("resume_wrap", 32'(b_w), 32'(i == 8));
    end

    // Random phase against the model
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(63) == 0);
      a_en   = ($urandom_range(3) != 0);
      b_en   = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) a_mode = ~a_mode;
      if ($urandom_range(15) == 0) b_mode = ~b_mode;
      a_sel  = 4'($urandom_range(15));
      b_sel  = 3'($urandom_range(7));
      a_in   = 16'($urandom);
      b_in   = 20'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_nmux.md
# scan_nmux

Parametrised, registered N:1 multiplexer: the successor to the combinational 16:1 bit mux, generalised to N_CH channels of W bits each. It has a manual-select mode and an auto-scan mode, in which an internal channel counter steps through all inputs with a programmable dwell. It sits between a bank of sensor/status sources and a single serial or debug consumer. Every output is registered.

## Interface
- N_CH, default 16: number of input channels, 2..256; need not be a power of two.
- W, default 1: data width per channel, 1..32.
- DWELL, default 1: cycles spent on each channel in scan mode, 1..65535.
- SEL_W, derived as max(1, clog2(N_CH)): width of the select field. Not overridable.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  N_CH*W  packed channel data; channel k is in[k*W +: W].
- sel  in  SEL_W  channel select used in manual mode.
- mode  in  1  0 = MANUAL, 1 = SCAN.
- en  in  1  1 = operate; 0 = freeze the state and the outputs.
- y  out  W  registered selected data.
- sel_out  out  SEL_W  channel index that produced y.
- valid  out  1  y/sel_out were updated at the last edge.
- wrap  out  1  one-cycle pulse when scan goes from channel N_CH-1 to channel 0.
- err  out  1  manual sel >= N_CH was sampled; y is forced to 0.

## Operation
- State machine has two states:
  - MAN: selects using sel.
  - SCAN: selects using the internal counter ch (SEL_W bits) and the dwell counter dc (16 bits).
  - Transitions on each edge with en=1: MAN→SCAN when mode=1; SCAN→MAN when mode=0. Otherwise the state holds.
- Entering SCAN loads ch=0 and dc=0. The first scan sample is channel 0 on the same edge as the transition.
- SCAN step, on each en=1 edge:
  - If dc==DWELL-1: dc←0; ch←(ch==N_CH-1) ? 0 : ch+1; wrap←1 only when ch was N_CH-1.
  - Otherwise dc←dc+1.
  - ch never takes a value >= N_CH, including for non-power-of-two N_CH.
- Output update, on each en=1 edge:
  - y←in[c*W +: W], sel_out←c, valid←1.
  - c is sel in MAN and the current ch in SCAN (the pre-increment value).
- MAN with sel >= N_CH: y←0, sel_out←sel, err←1, valid←1.
- err clears on the next en=1 edge with a legal selection, and is always 0 in SCAN.
- en=0: state, ch, dc, y, sel_out and err hold; valid←0; wrap←0.
- wrap is a single-cycle pulse. It is 0 in MAN and 0 on any edge where no wrap occurs.
- SCAN→MAN on the same edge that would wrap: MAN wins, wrap←0, and y samples sel.

## Timing
- Latency is 1 cycle: data and select present before edge n appear on y at edge n.
- In SCAN, y follows live input data, so a dwelled channel resamples every cycle.
- Channel k is presented for exactly DWELL consecutive en=1 cycles. A full scan period is N_CH*DWELL en=1 cycles.
- wrap asserts on the edge where y first shows channel 0 of a new pass (sel_out=0). It does not assert on SCAN entry.
- Reset values: y=0, sel_out=0, valid=0, wrap=0, err=0, state=MAN, ch=0, dc=0.
- rst overrides en and mode. Reset mid-scan aborts the scan, and the first post-reset sample follows the normal entry rule.
- There are no combinational paths from any input to any output.

## Test plan
- **Manual sweep** (N_CH=16, W=1, mode=0, en=1):
  - Stimulus: apply a one-hot in=16'h0001<<k with sel=k for k=0..15.
  - Required response: y=1, sel_out=k, valid=1 one cycle later each time.
  - Then in=16'h0400 with sel=3 gives y=0.
- **Scan wrap** (DWELL=1, in=16'hA5A5):
  - Stimulus: mode=1 for 34 cycles.
  - Required response: sel_out follows 0,1,…,15,0,1,…; y equals bit sel_out of 16'hA5A5.
  - wrap is high exactly on the two edges where sel_out returns to 0 after 15.
- **Dwell and pause** (DWELL=3, N_CH=5):
  - Required response: sel_out follows 0,0,0,1,1,1,…,4,4,4,0 and wrap fires with the first 0.
  - Stimulus: drop en for 4 cycles mid-channel-2.
  - Required response: outputs hold, valid=0 during the pause, and the remaining dwell count resumes exactly afterwards.
- **Illegal select** (N_CH=5, mode=0):
  - Stimulus: sel=6, then sel=2.
  - Required response: y=0, err=1, sel_out=6, then err=0 and y=in[2] on the following edge.
- **Mode switch**:
  - Stimulus: in SCAN at ch=9, set mode=0 with sel=4.
  - Required response: the next y is channel 4.
  - Stimulus: return to mode=1.
  - Required response: restarts at sel_out=0 with no wrap pulse.
- **Reset mid-scan**:
  - Stimulus: assert rst for 1 cycle at ch=7.
  - Required response: y=0, sel_out=0, valid=0, wrap=0, err=0, state MAN.
  - Stimulus: with mode held at 1, release rst.
  - Required response: re-enters SCAN with the first sample sel_out=0.
